// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int WIDTH    = 32;
    localparam int CNT_W    = 5;
    localparam int MULT_LAT = 33;
    localparam int DIV_LAT  = 36;

    // State | meaning
    // IDLE     | waiting for a start pulse
    // MULT     | 32 Booth add/sub + arithmetic-shift iterations
    // DIV_NEGA | dividend magnitude into the quotient register
    // DIV_NEGB | divisor magnitude into the divisor register
    // DIV      | 32 restoring shift/subtract iterations
    // DIV_FIX  | apply quotient sign, detect 0x80000000 / -1
    // DONE     | publish result, pulse ready
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MULT     = 3'd1,
        DIV_NEGA = 3'd2,
        DIV_NEGB = 3'd3,
        DIV      = 3'd4,
        DIV_FIX  = 3'd5,
        DONE     = 3'd6
    } state_e;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } add_op_e;

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder built from four chained 8-bit blocks.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic g0, g1, g2, g3;
    logic p0, p1, p2, p3;
    logic c1, c2, c3;

    // Block cout is group generate only, so each stage carry also needs
    // the P & carry-in term or a carry rippling through a block is lost.
    assign c1   = g0 | (p0 & cin);
    assign c2   = g1 | (p1 & c1);
    assign c3   = g2 | (p2 & c2);
    assign cout = g3 | (p3 & c3);

    cla8 u_blk0 (.a(a[7:0]),   .b(b[7:0]),   .cin(cin), .sum(sum[7:0]),   .cout(g0), .p(p0));
    cla8 u_blk1 (.a(a[15:8]),  .b(b[15:8]),  .cin(c1),  .sum(sum[15:8]),  .cout(g1), .p(p1));
    cla8 u_blk2 (.a(a[23:16]), .b(b[23:16]), .cin(c2),  .sum(sum[23:16]), .cout(g2), .p(p2));
    cla8 u_blk3 (.a(a[31:24]), .b(b[31:24]), .cin(c3),  .sum(sum[31:24]), .cout(g3), .p(p3));

endmodule

// File: rtl/cla8.sv
// 8-bit carry-lookahead block. cout is the group generate only; the
// propagate-all-with-carry-in term is added by the chaining logic.
module cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       p
);

    // Bit generate/propagate, internal carries, group generate/propagate.
    always_comb begin
        logic [7:0] g_bit;
        logic [7:0] p_bit;
        logic [7:0] c;
        logic       gg;
        g_bit = a & b;
        p_bit = a ^ b;
        c     = '0;
        c[0]  = cin;
        for (int i = 0; i < 7; i++) begin
            c[i+1] = g_bit[i] | (p_bit[i] & c[i]);
        end
        gg = 1'b0;
        for (int i = 0; i < 8; i++) begin
            gg = g_bit[i] | (p_bit[i] & gg);
        end
        sum  = p_bit ^ c;
        cout = gg;
        p    = &p_bit;
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring)
// sequencer around a single shared carry-lookahead adder.
module multdiv_sequencer
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    // acc: Booth accumulator (MULT) / partial remainder (DIV).
    // lo:  multiplier / product low (MULT), quotient (DIV).
    // m:   multiplicand (MULT), divisor (DIV).
    state_e           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             bq_q, bq_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exception_q, exception_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] add_a, add_x, add_b, add_sum;
    logic             add_cin, add_cout;
    add_op_e          add_op;

    logic [WIDTH:0]   acc_sum;
    logic             booth_en;
    logic             all_same;
    logic             neg_q;

    assign add_b   = (add_op == SUB) ? ~add_x : add_x;
    assign add_cin = (add_op == SUB);

    cla32 u_cla32 (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum),
        .cout(add_cout)
    );

    // Adder operand selection; depends only on registered state.
    always_comb begin
        add_a  = '0;
        add_x  = '0;
        add_op = ADD;
        unique case (state_q)
            MULT: begin
                add_a  = acc_q[WIDTH-1:0];
                add_x  = m_q;
                add_op = (lo_q[0] && !bq_q) ? SUB : ADD;
            end
            DIV_NEGA: begin
                add_x  = lo_q;
                add_op = SUB;
            end
            DIV_NEGB: begin
                add_x  = m_q;
                add_op = SUB;
            end
            DIV: begin
                add_a  = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
                add_x  = m_q;
                add_op = SUB;
            end
            DIV_FIX: begin
                add_x  = lo_q;
                add_op = SUB;
            end
            default: ;
        endcase
    end

    // Next-state, datapath updates and output registers; starts override.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        lo_d        = lo_q;
        bq_d        = bq_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        res_d       = res_q;
        exc_d       = exc_q;
        result_d    = result_q;
        exception_d = exception_q;
        rdy_d       = 1'b0;
        booth_en    = 1'b0;
        acc_sum     = acc_q;
        all_same    = 1'b0;
        neg_q       = sa_q ^ sb_q;

        unique case (state_q)
            MULT: begin
                booth_en = lo_q[0] ^ bq_q;
                // Bit 32 needs its own full-add so M = 0x80000000 negates correctly.
                if (booth_en) begin
                    acc_sum = {acc_q[WIDTH] ^ (m_q[WIDTH-1] ^ (add_op == SUB)) ^ add_cout,
                               add_sum};
                end
                acc_d = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
                lo_d  = {acc_sum[0], lo_q[WIDTH-1:1]};
                bq_d  = lo_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    all_same = (&{acc_d, lo_d[WIDTH-1]}) | ~(|{acc_d, lo_d[WIDTH-1]});
                    res_d    = lo_d;
                    exc_d    = ~all_same;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DIV_NEGA: begin
                if (lo_q[WIDTH-1]) lo_d = add_sum;
                state_d = DIV_NEGB;
            end
            DIV_NEGB: begin
                if (m_q[WIDTH-1]) m_d = add_sum;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = DIV;
            end
            DIV: begin
                // Carry out of R - D means the shifted remainder covers D.
                if (add_cout) begin
                    acc_d = {1'b0, add_sum};
                    lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {1'b0, add_a};
                    lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    cnt_d   = '0;
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                res_d   = neg_q ? add_sum : lo_q;
                exc_d   = ~neg_q & lo_q[WIDTH-1];
                state_d = DONE;
            end
            DONE: begin
                result_d    = res_q;
                exception_d = exc_q;
                rdy_d       = 1'b1;
                state_d     = IDLE;
            end
            default: ;
        endcase

        if (ctrl_MULT) begin
            acc_d   = '0;
            lo_d    = data_operandB;
            bq_d    = 1'b0;
            m_d     = data_operandA;
            cnt_d   = '0;
            state_d = MULT;
        end else if (ctrl_DIV) begin
            sa_d  = data_operandA[WIDTH-1];
            sb_d  = data_operandB[WIDTH-1];
            acc_d = '0;
            lo_d  = data_operandA;
            bq_d  = 1'b0;
            m_d   = data_operandB;
            cnt_d = '0;
            if (data_operandB == '0) begin
                res_d   = '0;
                exc_d   = 1'b1;
                state_d = DONE;
            end else begin
                state_d = DIV_NEGA;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            lo_q        <= '0;
            bq_q        <= 1'b0;
            m_q         <= '0;
            cnt_q       <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            res_q       <= '0;
            exc_q       <= 1'b0;
            result_q    <= '0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            bq_q        <= bq_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            res_q       <= res_d;
            exc_q       <= exc_d;
            result_q    <= result_d;
            exception_q <= exception_d;
            rdy_q       <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exception_q;
    assign data_resultRDY = rdy_q;

endmodule
